adder_accumulator: RTL and testbench
====================================

# adder_accumulator

Sequential accumulator placed directly downstream of the 4-bit ripple adder. It consumes the adder's 5-bit unsigned sum through a valid/ready handshake and adds `COUNT` consecutive sums into a wider register. It then presents the block total, with a sticky overflow flag, through a second valid/ready handshake. It is the first clocked stage after the combinational adder datapath.

## Interface
Parameters:
- `ACC_WIDTH`, default 8: accumulator width in bits; legal range 5..16.
- `COUNT`, default 4: number of sums per block; legal range 1..255.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: `in_sum` holds a valid adder result.
- `in_ready`  output  1: block accepts a sum this cycle.
- `in_sum`  input  5: unsigned adder output, range 0..30.
- `out_valid`  output  1: `out_acc` and `out_ovf` hold a completed block total.
- `out_ready`  input  1: consumer takes the total this cycle.
- `out_acc`  output  ACC_WIDTH: block total modulo 2^ACC_WIDTH.
- `out_ovf`  output  1: set if any addition in the block carried out of ACC_WIDTH.
- `busy`  output  1: at least one sum accepted in the current block, or a total pending.

## Operation
- State machine has two states, ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - Accept happens when `in_valid` and `in_ready` are both 1.
  - On accept: acc <= acc + zero-extended `in_sum`, truncated to ACC_WIDTH bits.
  - On accept: ovf <= ovf OR carry out of bit ACC_WIDTH-1.
  - On accept: cnt <= cnt + 1.
  - On an accept with cnt == COUNT-1: go to HOLD. cnt stays at that value; no increment beyond it.
- HOLD:
  - `in_ready`=0, `out_valid`=1.
  - `out_acc` and `out_ovf` are held stable.
  - `in_valid` is ignored and `in_sum` is not sampled.
  - On `out_valid` and `out_ready` both 1: acc, cnt and ovf clear to 0 and the state returns to ACCUM.
- Outputs:
  - `out_acc`=acc and `out_ovf`=ovf at all times; they are meaningful only while `out_valid`=1.
  - `busy`=1 when in HOLD, or when cnt != 0 in ACCUM.
- Counter `cnt` is 8 bits wide.
- COUNT=1: every accept moves directly to HOLD.
- `in_sum` values above 30 are not produced upstream. If they occur, they are added as-is with no checking.
- `out_ready` asserted in ACCUM has no effect.

## Timing
- Reset: while `rst`=1 at a rising edge, the next cycle has state=ACCUM, acc=0, cnt=0, ovf=0.
- During any cycle with `rst`=1: `in_ready`=0, `out_valid`=0, `busy`=0, `out_acc`=0, `out_ovf`=0. Handshakes do not complete during reset.
- Reset mid-block or in HOLD: partial sums and pending totals are discarded. No output handshake occurs.
- Throughput: one sum per cycle in ACCUM, with no bubbles between accepts.
- Latency: `out_valid` rises in the cycle after the edge that accepts the COUNT-th sum.
- HOLD lasts at least one cycle.
- The cycle after the output handshake: `in_ready`=1, acc=0.
  - Minimum period per block is COUNT+1 cycles when `out_ready` is held high.
- `in_ready` and `out_valid` are functions of state and `rst` only. Neither depends combinationally on `in_valid` or `out_ready`.
- No input is accepted in the same cycle as an output handshake.

## Test plan
- Reset check: hold `rst` for 2 cycles with `in_valid`=1 and `in_sum`=5.
  - Required: all outputs 0 during reset.
  - Required: cycle after reset release, `in_ready`=1 and acc=0.
- Basic block (defaults): feed sums 3, 10, 30, 7 back-to-back, `out_ready`=1.
  - Required: one cycle after the 4th accept, `out_valid`=1, `out_acc`=50, `out_ovf`=0.
  - Required: next cycle `in_ready`=1 and `busy`=0.
- Backpressure in HOLD: same stimulus, `out_ready`=0 for 5 cycles, with `in_valid`=1 and `in_sum`=9 held throughout.
  - Required: `out_acc`=50 stable for all 5 cycles, `in_ready`=0, and the 9s are not absorbed.
  - Required: after `out_ready`=1, the next block starts from 0.
- Overflow (COUNT=16, ACC_WIDTH=8): 16 consecutive sums of 30.
  - Required: `out_acc`=480 mod 256=224, `out_ovf`=1.
  - Required: the following block of 16 sums of 1 gives `out_acc`=16, `out_ovf`=0.
- Gapped input: sums 1, 2, 3, 4 with `in_valid` low for 2 cycles between each.
  - Required: `out_acc`=10.
  - Required: `busy`=1 from the first accept until the output handshake.
- Mid-block reset: accept 2 sums of 15, assert `rst` for 1 cycle, then feed 4 sums of 2.
  - Required: `out_acc`=8, `out_ovf`=0; no output handshake before the reset.

Source files
------------

// File: rtl/adder_accumulator.sv
// Accumulates COUNT consecutive 5-bit adder sums into an ACC_WIDTH-bit total
// with a sticky carry-out flag; the total leaves through a valid/ready port.
module adder_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf,
  output logic                 busy
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_ext;

  // One extra bit on the adder exposes the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH - 4){1'b0}}, in_sum};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          acc_d = sum_ext[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum_ext[ACC_WIDTH];
          if (cnt_q == LAST_CNT) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        out_valid = !rst;
        if (out_valid && out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  assign out_acc = rst ? '0 : acc_q;
  assign out_ovf = rst ? 1'b0 : ovf_q;
  assign busy    = !rst && ((state_q == HOLD) || (cnt_q != 8'd0));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: a default instance and a COUNT=16 instance,
// with expected totals queued at stimulus time and popped at output handshakes.
module tb_adder_accumulator;

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [4:0] sums [4];
    int         gap;
    logic [7:0] acc;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [4:0] a_in_sum;
  logic [7:0] a_out_acc;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [4:0] b_in_sum;
  logic [7:0] b_out_acc;

  int   n_checks = 0;
  int   n_errors = 0;
  int   a_hs     = 0;
  exp_t a_q[$];
  exp_t b_q[$];

  always #5 clk = ~clk;

  adder_accumulator u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  adder_accumulator #(.ACC_WIDTH(8), .COUNT(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: a handshake completes at the next rising edge when both are high.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_hs++;
      if (a_q.size() == 0) begin
        check("a_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = a_q.pop_front();
        check("a_sb_acc", {24'd0, a_out_acc}, {16'd0, e.acc});
        check("a_sb_ovf", {31'd0, a_out_ovf}, {31'd0, e.ovf});
      end
    end
    if (b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        check("b_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = b_q.pop_front();
        check("b_sb_acc", {24'd0, b_out_acc}, {16'd0, e.acc});
        check("b_sb_ovf", {31'd0, b_out_ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one sum and returns 1 time unit after the edge that accepts it.
  task automatic send_a(input logic [4:0] s);
    int waited = 0;
    a_in_valid = 1'b1;
    a_in_sum   = s;
    @(negedge clk);
    while (!a_in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("a_accept_timeout", 32'd1, 32'd0);
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] s);
    int waited = 0;
    b_in_valid = 1'b1;
    b_in_sum   = s;
    @(negedge clk);
    while (!b_in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("b_accept_timeout", 32'd1, 32'd0);
    step();
    b_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   hs_before;

    vecs[0] = '{sums: '{5'd3,  5'd10, 5'd30, 5'd7},  gap: 0, acc: 8'd50,  ovf: 1'b0};
    vecs[1] = '{sums: '{5'd30, 5'd30, 5'd30, 5'd30}, gap: 0, acc: 8'd120, ovf: 1'b0};
    vecs[2] = '{sums: '{5'd0,  5'd0,  5'd0,  5'd0},  gap: 1, acc: 8'd0,   ovf: 1'b0};
    vecs[3] = '{sums: '{5'd31, 5'd31, 5'd31, 5'd31}, gap: 3, acc: 8'd124, ovf: 1'b0};

    rst = 1'b1;
    a_in_valid = 1'b1; a_in_sum = 5'd5; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sum = 5'd0; b_out_ready = 1'b1;

    // Reset held two cycles with a valid sum on the input.
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst%0d_in_ready", i),  {31'd0, a_in_ready},  32'd0);
      check($sformatf("rst%0d_out_valid", i), {31'd0, a_out_valid}, 32'd0);
      check($sformatf("rst%0d_busy", i),      {31'd0, a_busy},      32'd0);
      check($sformatf("rst%0d_out_acc", i),   {24'd0, a_out_acc},   32'd0);
      check($sformatf("rst%0d_out_ovf", i),   {31'd0, a_out_ovf},   32'd0);
    end
    rst = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("post_rst_out_acc",  {24'd0, a_out_acc},  32'd0);
    check("post_rst_busy",     {31'd0, a_busy},     32'd0);

    // Table-driven blocks with the consumer always ready.
    a_out_ready = 1'b1;
    foreach (vecs[v]) begin
      a_q.push_back('{acc: {8'd0, vecs[v].acc}, ovf: vecs[v].ovf});
      for (int k = 0; k < 4; k++) begin
        send_a(vecs[v].sums[k]);
        if (k < 3) repeat (vecs[v].gap) step();
      end
      check($sformatf("vec%0d_out_valid", v), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("vec%0d_out_acc", v),   {24'd0, a_out_acc},   {24'd0, vecs[v].acc});
      check($sformatf("vec%0d_out_ovf", v),   {31'd0, a_out_ovf},   {31'd0, vecs[v].ovf});
      step();
      check($sformatf("vec%0d_next_in_ready", v), {31'd0, a_in_ready}, 32'd1);
      check($sformatf("vec%0d_next_busy", v),     {31'd0, a_busy},     32'd0);
    end

    // Backpressure: the total must hold while 9s are offered and refused.
    a_out_ready = 1'b0;
    a_q.push_back('{acc: 16'd50, ovf: 1'b0});
    send_a(5'd3); send_a(5'd10); send_a(5'd30); send_a(5'd7);
    a_in_valid = 1'b1;
    a_in_sum   = 5'd9;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_valid", c), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("bp%0d_out_acc", c),   {24'd0, a_out_acc},   32'd50);
      check($sformatf("bp%0d_in_ready", c),  {31'd0, a_in_ready},  32'd0);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("bp_release_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("bp_release_out_acc",   {24'd0, a_out_acc},   32'd0);
    check("bp_release_busy",      {31'd0, a_busy},      32'd0);
    a_q.push_back('{acc: 16'd4, ovf: 1'b0});
    send_a(5'd1); send_a(5'd1); send_a(5'd1); send_a(5'd1);
    check("bp_next_block_acc", {24'd0, a_out_acc}, 32'd4);
    step();

    // Gapped input: busy stays high from the first accept to the handshake.
    a_q.push_back('{acc: 16'd10, ovf: 1'b0});
    for (int k = 1; k <= 4; k++) begin
      send_a(5'(k));
      check($sformatf("gap_busy_acc%0d", k), {31'd0, a_busy}, 32'd1);
      if (k < 4) begin
        for (int g = 0; g < 2; g++) begin
          step();
          check($sformatf("gap_busy_idle%0d_%0d", k, g), {31'd0, a_busy}, 32'd1);
        end
      end
    end
    check("gap_out_acc", {24'd0, a_out_acc}, 32'd10);
    step();
    check("gap_busy_after_hs", {31'd0, a_busy}, 32'd0);

    // Mid-block reset discards the partial sum without a handshake.
    hs_before = a_hs;
    send_a(5'd15); send_a(5'd15);
    rst = 1'b1;
    step();
    check("midrst_busy",      {31'd0, a_busy},      32'd0);
    check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_no_hs", a_hs, hs_before);
    check("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_q.push_back('{acc: 16'd8, ovf: 1'b0});
    send_a(5'd2); send_a(5'd2); send_a(5'd2); send_a(5'd2);
    check("midrst_out_acc", {24'd0, a_out_acc}, 32'd8);
    check("midrst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
    step();

    // Wider block on the COUNT=16 instance: overflow, then a clean block.
    b_q.push_back('{acc: 16'd224, ovf: 1'b1});
    for (int k = 0; k < 16; k++) send_b(5'd30);
    check("ovf_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("ovf_out_acc",   {24'd0, b_out_acc},   32'd224);
    check("ovf_out_ovf",   {31'd0, b_out_ovf},   32'd1);
    b_q.push_back('{acc: 16'd16, ovf: 1'b0});
    for (int k = 0; k < 16; k++) send_b(5'd1);
    check("ovf_next_out_acc", {24'd0, b_out_acc}, 32'd16);
    check("ovf_next_out_ovf", {31'd0, b_out_ovf}, 32'd0);
    step();
    step();

    check("a_queue_drained", a_q.size(), 32'd0);
    check("b_queue_drained", b_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
